spm_multibank_ctrl: RTL and testbench

- Parametrised multi-port, multi-bank scratchpad controller for accelerator tiles.
- Replaces the fixed two-port scratchpad with NUM_PORTS requestor channels (NoC decoder, AXI/RISC-V, accelerator datapaths) sharing NUM_BANKS word-interleaved banks.
- Arbitration is round-robin per bank. Requests use a valid/ready handshake and byte strobes. Responses are registered and flag out-of-range accesses.
- A saturating bank-conflict counter supports profiling.

---
 rtl/spm_multibank_ctrl_pkg.sv | 41 ++++
 rtl/spm_multibank_ctrl_rr_arbiter.sv | 41 ++++
 rtl/spm_multibank_ctrl.sv | 146 ++++++++++++++
 tb/tb_spm_multibank_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spm_multibank_ctrl_pkg.sv
// Shared sizing helpers and request/response records for the multi-bank scratchpad.
package spm_pkg;

  localparam int SPM_ADDR_W = 32;
  localparam int SPM_DATA_W = 32;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int bank_bits(input int nb);
    return $clog2(nb);
  endfunction

  function automatic int row_w(input int offset_sz, input int nb);
    return offset_sz - $clog2(nb);
  endfunction

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  typedef struct packed {
    logic                    we;
    logic [SPM_ADDR_W-1:0]   addr;
    logic [SPM_DATA_W-1:0]   wdata;
    logic [SPM_DATA_W/8-1:0] wstrb;
  } spm_req_t;

  typedef struct packed {
    logic                  valid;
    logic [SPM_DATA_W-1:0] rdata;
    logic                  err;
  } spm_rsp_t;

endpackage

// File: rtl/spm_multibank_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner.
module spm_rr_arbiter
  import spm_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_low,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = clog2_min1(NUM_REQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic          hit;
  int            idx;

  always_comb begin
    grant = '0;
    win   = rr_ptr;
    hit   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = PW'(idx);
      end
    end
    if (hit) grant[win] = 1'b1;
    else     grant = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_low)  rr_ptr <= '0;
    else if (hit)  rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
  end

endmodule

// File: rtl/spm_multibank_ctrl.sv
// Multi-port scratchpad over word-interleaved banks with per-bank round-robin arbitration,
// one-cycle registered responses, range checking and a saturating conflict counter.
module spm_multibank_ctrl
  import spm_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32,
  parameter int OFFSET_SZ = 12,
  parameter int CNT_W     = 16
) (
  input  logic                        clk_ctrl,
  input  logic                        clk_ctrl_rst_low,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*32-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rsp_rdata,
  output logic [NUM_PORTS-1:0]        rsp_err,
  input  logic                        conf_clr,
  output logic [CNT_W-1:0]            conf_cnt
);

  localparam int BB     = bank_bits(NUM_BANKS);
  localparam int BW     = clog2_min1(NUM_BANKS);
  localparam int PW     = clog2_min1(NUM_PORTS);
  localparam int ROW_W  = row_w(OFFSET_SZ, NUM_BANKS);
  localparam int STRB_W = strb_w(DATA_W);
  localparam int ROWS   = 1 << ROW_W;

  logic [OFFSET_SZ-1:0] word    [NUM_PORTS];
  logic [BW-1:0]        bank    [NUM_PORTS];
  logic [ROW_W-1:0]     row     [NUM_PORTS];
  logic [DATA_W-1:0]    wdata   [NUM_PORTS];
  logic [STRB_W-1:0]    wstrb   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_range;
  logic [NUM_PORTS-1:0] granted;
  logic [NUM_PORTS-1:0] gnt_bank [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rd  [NUM_BANKS];

  logic [NUM_PORTS-1:0] rsp_valid_r;
  logic [NUM_PORTS-1:0] rsp_err_r;
  logic [NUM_PORTS-1:0] rsp_read_r;
  logic [BW-1:0]        rsp_bank_r [NUM_PORTS];

  // Banks are interleaved on the low word-address bits; rows come from the rest.
  always_comb begin
    in_range = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      word[p]     = req_addr[p*32+2 +: OFFSET_SZ];
      bank[p]     = BW'(word[p] & OFFSET_SZ'(NUM_BANKS - 1));
      row[p]      = ROW_W'(word[p] >> BB);
      wdata[p]    = req_wdata[p*DATA_W +: DATA_W];
      wstrb[p]    = req_wstrb[p*STRB_W +: STRB_W];
      in_range[p] = (req_addr[p*32+OFFSET_SZ+2 +: 30-OFFSET_SZ] == '0);
    end
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < NUM_BANKS; b++) granted = granted | gnt_bank[b];
  end

  // Out-of-range requests bypass arbitration so they are never stalled.
  assign req_ready = {NUM_PORTS{clk_ctrl_rst_low}} & req_valid & (granted | ~in_range);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] gnt;
    logic [PW-1:0]        sel;
    logic [DATA_W-1:0]    mem [ROWS];
    logic [DATA_W-1:0]    rd;

    always_comb begin
      cand = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cand[p] = clk_ctrl_rst_low & req_valid[p] & in_range[p] & (bank[p] == BW'(b));
      end
    end

    always_comb begin
      sel = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt[p]) sel = PW'(p);
      end
    end

    spm_rr_arbiter #(.NUM_REQ(NUM_PORTS)) u_arb (
      .clk     (clk_ctrl),
      .rst_low (clk_ctrl_rst_low),
      .req     (cand),
      .grant   (gnt)
    );

    // Read-before-write port: rd captures the row as it was at the accepting edge.
    always_ff @(posedge clk_ctrl) begin
      if (|gnt) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (req_we[sel] && wstrb[sel][i]) mem[row[sel]][i*8 +: 8] <= wdata[sel][i*8 +: 8];
        end
        rd <= mem[row[sel]];
      end
    end

    assign gnt_bank[b] = gnt;
    assign bank_rd[b]  = rd;
  end

  always_ff @(posedge clk_ctrl) begin
    if (!clk_ctrl_rst_low) begin
      rsp_valid_r <= '0;
      rsp_err_r   <= '0;
      rsp_read_r  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rsp_bank_r[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_valid_r[p] <= req_valid[p] & req_ready[p];
        rsp_err_r[p]   <= req_valid[p] & req_ready[p] & ~in_range[p];
        rsp_read_r[p]  <= req_valid[p] & req_ready[p] & in_range[p] & ~req_we[p];
        rsp_bank_r[p]  <= bank[p];
      end
    end
  end

  // Gating with reset suppresses a response whose request was accepted just before reset.
  assign rsp_valid = rsp_valid_r & {NUM_PORTS{clk_ctrl_rst_low}};
  assign rsp_err   = rsp_err_r & {NUM_PORTS{clk_ctrl_rst_low}};

  always_comb begin
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (clk_ctrl_rst_low && rsp_read_r[p]) rsp_rdata[p*DATA_W +: DATA_W] = bank_rd[rsp_bank_r[p]];
      else                                   rsp_rdata[p*DATA_W +: DATA_W] = '0;
    end
  end

  always_ff @(posedge clk_ctrl) begin
    if (!clk_ctrl_rst_low)                               conf_cnt <= '0;
    else if (conf_clr)                                   conf_cnt <= '0;
    else if ((|(req_valid & ~req_ready)) && (conf_cnt != '1)) conf_cnt <= conf_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_spm_multibank_ctrl.sv
// Directed bench for spm_multibank_ctrl: a default instance plus a 4-bit-counter instance on shared stimulus.
module tb_spm_multibank_ctrl;

  logic        clk;
  logic        rst_low;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        conf_clr;

  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [15:0] conf_cnt;

  logic [1:0]  s_ready, s_rsp_valid, s_rsp_err;
  logic [63:0] s_rsp_rdata;
  logic [3:0]  s_conf_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_g;

  spm_multibank_ctrl u_dut (
    .clk_ctrl(clk), .clk_ctrl_rst_low(rst_low),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .conf_clr(conf_clr), .conf_cnt(conf_cnt)
  );

  spm_multibank_ctrl #(.CNT_W(4)) u_sat (
    .clk_ctrl(clk), .clk_ctrl_rst_low(rst_low),
    .req_valid(req_valid), .req_ready(s_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
    .conf_clr(conf_clr), .conf_cnt(s_conf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[p]         = 1'b1;
    req_we[p]            = we;
    req_addr[p*32 +: 32] = a;
    req_wdata[p*32 +: 32] = d;
    req_wstrb[p*4 +: 4]  = s;
  endtask

  initial begin
    rst_low   = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = 64'h0;
    req_wdata = 64'h0;
    req_wstrb = 8'h0;
    conf_clr  = 1'b0;

    // Reset held for three cycles with every port requesting
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rdata", rsp_rdata, 64'h0);
    chk("reset_conf", 64'(conf_cnt), 64'h0);
    chk("reset_conf_sat", 64'(s_conf_cnt), 64'h0);

    rst_low   = 1'b1;
    req_valid = 2'b00;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("first_read_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("first_read_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("first_read_err", 64'(rsp_err), 64'h0);

    // Byte-strobe merge at 0x010
    set_req(0, 1'b1, 32'h010, 32'h11223344, 4'hF);
    #1;
    chk("wr1_ready", 64'(req_ready), 64'h1);
    tick();
    chk("wr1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("wr1_rdata_zero", rsp_rdata, 64'h0);
    set_req(0, 1'b1, 32'h010, 32'hAABBCCDD, 4'b0101);
    tick();
    chk("wr2_rsp_valid", 64'(rsp_valid), 64'h1);
    set_req(0, 1'b0, 32'h010, 32'h0, 4'h0);
    tick();
    req_valid = 2'b00;
    chk("rd_merge_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("rd_merge_rdata", 64'(rsp_rdata[31:0]), 64'h11BB33DD);
    tick();
    chk("rsp_single_pulse", 64'(rsp_valid), 64'h0);

    // Parallel writes then crossed parallel reads on banks 0 and 1
    set_req(0, 1'b1, 32'h004, 32'h0BADF00D, 4'hF);
    set_req(1, 1'b1, 32'h000, 32'h5A5A1234, 4'hF);
    #1;
    chk("par_wr_ready", 64'(req_ready), 64'h3);
    tick();
    chk("par_wr_rsp_valid", 64'(rsp_valid), 64'h3);
    set_req(0, 1'b0, 32'h004, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h000, 32'h0, 4'h0);
    #1;
    chk("par_rd_ready", 64'(req_ready), 64'h3);
    tick();
    req_valid = 2'b00;
    chk("par_rd_rsp_valid", 64'(rsp_valid), 64'h3);
    chk("par_rd_rdata", rsp_rdata, 64'h5A5A1234_0BADF00D);
    chk("par_conf", 64'(conf_cnt), 64'h0);

    // Two ports contending for bank 0: grants alternate starting at port 0
    set_req(0, 1'b0, 32'h020, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h020, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_ready", 64'(req_ready), 64'(exp_g));
      tick();
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(exp_g));
    end
    req_valid = 2'b00;
    chk("rr_conf", 64'(conf_cnt), 64'h4);
    chk("rr_conf_sat", 64'(s_conf_cnt), 64'h4);
    conf_clr = 1'b1;
    tick();
    conf_clr = 1'b0;
    chk("clr_conf", 64'(conf_cnt), 64'h0);
    chk("clr_conf_sat", 64'(s_conf_cnt), 64'h0);

    // Out-of-range write aliasing onto row 0 of bank 0 must not land
    set_req(1, 1'b1, 32'h4000, 32'hDEADBEEF, 4'hF);
    #1;
    chk("oor_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    chk("oor_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("oor_err", 64'(rsp_err), 64'h2);
    chk("oor_rdata", rsp_rdata, 64'h0);
    set_req(0, 1'b0, 32'h000, 32'h0, 4'h0);
    tick();
    req_valid = 2'b00;
    chk("oor_nocorrupt_err", 64'(rsp_err), 64'h0);
    chk("oor_nocorrupt_rdata", 64'(rsp_rdata[31:0]), 64'h5A5A1234);

    // Twenty cycles of continuous conflict
    set_req(0, 1'b0, 32'h020, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h020, 32'h0, 4'h0);
    repeat (20) tick();
    req_valid = 2'b00;
    chk("sat_conf_4bit", 64'(s_conf_cnt), 64'hF);
    chk("sat_conf_16bit", 64'(conf_cnt), 64'd20);

    // Accept a read, then reset: no response, pointers back to port 0
    set_req(0, 1'b0, 32'h010, 32'h0, 4'h0);
    tick();
    rst_low   = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_mid_rdata", rsp_rdata, 64'h0);
    tick();
    chk("rst_mid_rsp_valid_after", 64'(rsp_valid), 64'h0);
    chk("rst_mid_conf", 64'(conf_cnt), 64'h0);
    rst_low = 1'b1;
    set_req(0, 1'b0, 32'h020, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h020, 32'h0, 4'h0);
    #1;
    chk("rst_ptr_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("rst_ptr_rsp_valid", 64'(rsp_valid), 64'h1);
    tick();
    chk("final_idle", 64'(rsp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
